// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
// Holds the FSM state encoding, the timeout counter width and the
// rotating-priority pick function used by wb_rr_pick.
package wb_arb_pkg;

   // Arbiter FSM states; ABORT is only reachable with WB_ARB_TIMEOUT_EN.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWNED = 2'd1,
      ABORT = 2'd2
   } arb_state_e;

   // Width of the stall counter used by the optional timeout.
   localparam int TO_CNT_W = 16;

   // Largest supported master count; rr_pick works on vectors of this width.
   localparam int MAX_M = 8;

   // Return the first requesting index scanning last+1, last+2, ... modulo numm.
   // The previous owner is examined last, so it cannot starve the others.
   function automatic logic [2:0] rr_pick(input logic [MAX_M-1:0] req,
                                          input logic [2:0]       last,
                                          input int               numm);
      logic [2:0] idx;
      logic       found;
      int         cand;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int k = 1; k <= MAX_M; k++) begin
         if (k <= numm) begin
            cand = (int'(last) + k) % numm;
            if (!found && req[cand[2:0]]) begin
               idx   = cand[2:0];
               found = 1'b1;
            end
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Arbitration signals between the shared-bus interconnect and the arbiter.
// slave  : the arbiter view (takes requests and slave responses, drives grants).
// master : the interconnect view (feeds requests/responses, steers muxes from grants).
interface wb_rr_arbiter_if #(
   parameter int NUMM = 3
);
   localparam int IDXW = $clog2(NUMM);

   logic [NUMM-1:0] m_cyc;
   logic [NUMM-1:0] m_stb;
   logic            s_ack;
   logic            s_err;
   logic [NUMM-1:0] gnt;
   logic [IDXW-1:0] gnt_idx;
   logic            busy;
   logic [NUMM-1:0] m_err_force;

   modport slave (
      input  m_cyc, m_stb, s_ack, s_err,
      output gnt, gnt_idx, busy, m_err_force
   );

   modport master (
      output m_cyc, m_stb, s_ack, s_err,
      input  gnt, gnt_idx, busy, m_err_force
   );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational rotating priority encoder: picks the next requester after
// 'last' in circular order. 'valid' is high when any request is present.
module wb_rr_pick
   import wb_arb_pkg::*;
#(
   parameter int NUMM = 3,
   localparam int IDXW = $clog2(NUMM)
) (
   input  logic [NUMM-1:0] req,
   input  logic [IDXW-1:0] last,
   output logic [IDXW-1:0] idx,
   output logic            valid
);

   logic [MAX_M-1:0] req_ext;
   logic [2:0]       last_ext;
   logic [2:0]       pick;

   assign req_ext  = MAX_M'(req);
   assign last_ext = 3'(last);
   assign pick     = rr_pick(req_ext, last_ext, NUMM);
   assign idx      = IDXW'(pick);
   assign valid    = |req;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter for the shared Wishbone bus.
// Grants one master for a whole CYC, hands over without an idle cycle when
// others are waiting, and rotates priority so no master is starved.
// Optional feature macro: WB_ARB_TIMEOUT_EN -- adds a stall counter that
// forces ERR to the owner after TIMEOUT stalled strobes and enters ABORT.
module wb_rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUMM    = 3,
   parameter int TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst_n,
   wb_rr_arbiter_if.slave bus
);

   localparam int IDXW = $clog2(NUMM);
   localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

   arb_state_e      state;
   logic [NUMM-1:0] gnt_q;
   logic [IDXW-1:0] idx_q;
   logic [IDXW-1:0] last_q;
   logic            busy_q;

   logic [IDXW-1:0] pick_idx;
   logic            pick_valid;
   logic            owner_cyc;
   logic            rearb;

   function automatic logic [NUMM-1:0] onehot(input logic [IDXW-1:0] i);
      logic [NUMM-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   wb_rr_pick #(.NUMM(NUMM)) u_pick (
      .req   (bus.m_cyc),
      .last  (last_q),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // Arbitrate when idle, or in the same cycle the current owner drops CYC.
   assign owner_cyc = bus.m_cyc[idx_q];
   assign rearb     = (state == IDLE) || !owner_cyc;

`ifdef WB_ARB_TIMEOUT_EN
   logic [TO_CNT_W-1:0] to_cnt;
   logic [NUMM-1:0]     err_q;
   logic                owner_stb;

   assign owner_stb = bus.m_stb[idx_q];
`else
   logic unused_inputs;
   assign unused_inputs = ^{bus.m_stb, bus.s_ack, bus.s_err, TO_LAST};
`endif

   // Ownership FSM: grant, hold for the whole cycle, release or hand over.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the reset branch clears every register so the grant drops
      // asynchronously; last starts at NUMM-1 so master 0 wins first.
      if (!rst_n) begin
         state  <= IDLE;
         gnt_q  <= '0;
         idx_q  <= '0;
         last_q <= IDXW'(NUMM - 1);
         busy_q <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
         to_cnt <= '0;
         err_q  <= '0;
`endif
      end else begin
`ifdef WB_ARB_TIMEOUT_EN
         err_q <= '0;
`endif
         if (rearb) begin
            if (pick_valid) begin
               // NOTE: non-blocking assignments keep every register update
               // reading the pre-edge values, as real flops do.
               gnt_q  <= onehot(pick_idx);
               idx_q  <= pick_idx;
               last_q <= pick_idx;
               busy_q <= 1'b1;
               state  <= OWNED;
`ifdef WB_ARB_TIMEOUT_EN
               to_cnt <= '0;
`endif
            end else begin
               gnt_q  <= '0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         end
`ifdef WB_ARB_TIMEOUT_EN
         else if (state == OWNED) begin
            if (bus.s_ack || bus.s_err) begin
               to_cnt <= '0;
            end else if (owner_stb) begin
               to_cnt <= to_cnt + TO_CNT_W'(1);
               if (to_cnt == TO_LAST) begin
                  err_q <= onehot(idx_q);
                  state <= ABORT;
               end
            end
         end
`endif
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.gnt_idx = idx_q;
   assign bus.busy    = busy_q;
`ifdef WB_ARB_TIMEOUT_EN
   assign bus.m_err_force = err_q;
`else
   assign bus.m_err_force = '0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter (NUMM=3, TIMEOUT=4).
// Each scenario pushes the expected grant state when it drives a cycle and
// pops/compares it once the arbiter has registered its response.
module tb_wb_rr_arbiter;

   localparam int NUMM    = 3;
   localparam int TIMEOUT = 4;

`ifdef WB_ARB_TIMEOUT_EN
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif

   typedef struct packed {
      logic [2:0] gnt;
      logic [1:0] idx;
      logic       busy;
      logic [2:0] ef;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   obs_t exp_q[$];

   wb_rr_arbiter_if #(.NUMM(NUMM)) bus ();

   wb_rr_arbiter #(.NUMM(NUMM), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic obs_t mk(input logic [2:0] g, input logic [1:0] i,
                               input logic b, input logic [2:0] ef);
      obs_t o;
      o.gnt  = g;
      o.idx  = i;
      o.busy = b;
      o.ef   = ef;
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.gnt  = bus.gnt;
      o.idx  = bus.gnt_idx;
      o.busy = bus.busy;
      o.ef   = bus.m_err_force;
      return o;
   endfunction

   // Drive one cycle of inputs, record what must appear after the edge.
   task automatic drive(input logic [2:0] cyc, input logic [2:0] stb,
                        input logic ack, input obs_t exp);
      bus.m_cyc = cyc;
      bus.m_stb = stb;
      bus.s_ack = ack;
      bus.s_err = 1'b0;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      bus.m_cyc = '0;
      bus.m_stb = '0;
      bus.s_ack = 1'b0;
      bus.s_err = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      obs_t e, a;
      rst_n     = 1'b0;
      bus.m_cyc = '0;
      bus.m_stb = '0;
      bus.s_ack = 1'b0;
      bus.s_err = 1'b0;
      #2;
      exp_q.push_back(mk(3'b000, 2'd0, 1'b0, 3'b000));
      e = exp_q.pop_front();
      a = sample();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL reset: got gnt=%b idx=%0d busy=%b ef=%b, want gnt=%b idx=%0d busy=%b ef=%b",
                  a.gnt, a.idx, a.busy, a.ef, e.gnt, e.idx, e.busy, e.ef);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic [2:0] cy[4];
      obs_t       ex[4];
      obs_t       e, a;
      apply_reset();
      cy = '{3'b010, 3'b010, 3'b000, 3'b000};
      ex = '{mk(3'b010, 2'd1, 1'b1, 3'b000), mk(3'b010, 2'd1, 1'b1, 3'b000),
             mk(3'b000, 2'd0, 1'b0, 3'b000), mk(3'b000, 2'd0, 1'b0, 3'b000)};
      for (int i = 0; i < 4; i++) begin
         drive(cy[i], 3'b000, 1'b0, ex[i]);
         e = exp_q.pop_front();
         a = sample();
         checks++;
         if (a.gnt !== e.gnt || a.busy !== e.busy || a.ef !== e.ef || (e.busy && a.idx !== e.idx)) begin
            errors++;
            $display("FAIL single[%0d]: got gnt=%b idx=%0d busy=%b ef=%b, want gnt=%b idx=%0d busy=%b ef=%b",
                     i, a.gnt, a.idx, a.busy, a.ef, e.gnt, e.idx, e.busy, e.ef);
         end
      end
   endtask

   task automatic test_contention();
      logic [2:0] cy[7];
      obs_t       ex[7];
      obs_t       e, a;
      apply_reset();
      // Each owner drops CYC for one cycle; the others stay requesting.
      cy = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011};
      ex = '{mk(3'b001, 2'd0, 1'b1, 3'b000), mk(3'b001, 2'd0, 1'b1, 3'b000),
             mk(3'b010, 2'd1, 1'b1, 3'b000), mk(3'b010, 2'd1, 1'b1, 3'b000),
             mk(3'b100, 2'd2, 1'b1, 3'b000), mk(3'b100, 2'd2, 1'b1, 3'b000),
             mk(3'b001, 2'd0, 1'b1, 3'b000)};
      for (int i = 0; i < 7; i++) begin
         drive(cy[i], 3'b000, (i % 2) == 1, ex[i]);
         e = exp_q.pop_front();
         a = sample();
         checks++;
         if (a.gnt !== e.gnt || a.busy !== e.busy || a.ef !== e.ef || (e.busy && a.idx !== e.idx)) begin
            errors++;
            $display("FAIL contention[%0d]: got gnt=%b idx=%0d busy=%b ef=%b, want gnt=%b idx=%0d busy=%b ef=%b",
                     i, a.gnt, a.idx, a.busy, a.ef, e.gnt, e.idx, e.busy, e.ef);
         end
      end
   endtask

   task automatic test_hold();
      obs_t e, a;
      logic [2:0] cy;
      apply_reset();
      for (int i = 0; i < 13; i++) begin
         if (i == 0) begin
            cy = 3'b100;
            e  = mk(3'b100, 2'd2, 1'b1, 3'b000);
         end else if (i <= 10) begin
            cy = 3'b111;
            e  = mk(3'b100, 2'd2, 1'b1, 3'b000);
         end else begin
            cy = 3'b011;
            e  = mk(3'b001, 2'd0, 1'b1, 3'b000);
         end
         drive(cy, 3'b000, 1'b0, e);
         e = exp_q.pop_front();
         a = sample();
         checks++;
         if (a.gnt !== e.gnt || a.busy !== e.busy || a.ef !== e.ef || (e.busy && a.idx !== e.idx)) begin
            errors++;
            $display("FAIL hold[%0d]: got gnt=%b idx=%0d busy=%b ef=%b, want gnt=%b idx=%0d busy=%b ef=%b",
                     i, a.gnt, a.idx, a.busy, a.ef, e.gnt, e.idx, e.busy, e.ef);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] cy[6];
      obs_t       ex[6];
      obs_t       e, a;
      apply_reset();
      // Final step re-arbitrates from IDLE with last=1: scan 2,0 -> master 0.
      cy = '{3'b001, 3'b011, 3'b010, 3'b010, 3'b000, 3'b011};
      ex = '{mk(3'b001, 2'd0, 1'b1, 3'b000), mk(3'b001, 2'd0, 1'b1, 3'b000),
             mk(3'b010, 2'd1, 1'b1, 3'b000), mk(3'b010, 2'd1, 1'b1, 3'b000),
             mk(3'b000, 2'd0, 1'b0, 3'b000), mk(3'b001, 2'd0, 1'b1, 3'b000)};
      for (int i = 0; i < 6; i++) begin
         drive(cy[i], 3'b000, 1'b0, ex[i]);
         e = exp_q.pop_front();
         a = sample();
         checks++;
         if (a.gnt !== e.gnt || a.busy !== e.busy || a.ef !== e.ef || (e.busy && a.idx !== e.idx)) begin
            errors++;
            $display("FAIL back_to_back[%0d]: got gnt=%b idx=%0d busy=%b ef=%b, want gnt=%b idx=%0d busy=%b ef=%b",
                     i, a.gnt, a.idx, a.busy, a.ef, e.gnt, e.idx, e.busy, e.ef);
         end
      end
   endtask

   task automatic test_reset_mid();
      obs_t e, a;
      apply_reset();
      drive(3'b010, 3'b000, 1'b0, mk(3'b010, 2'd1, 1'b1, 3'b000));
      e = exp_q.pop_front();
      a = sample();
      checks++;
      if (a.gnt !== e.gnt || a.busy !== e.busy || a.idx !== e.idx) begin
         errors++;
         $display("FAIL reset_mid_owned: got gnt=%b idx=%0d busy=%b, want gnt=%b idx=%0d busy=%b",
                  a.gnt, a.idx, a.busy, e.gnt, e.idx, e.busy);
      end
      // Assert reset between edges; the grant must drop with no clock.
      rst_n = 1'b0;
      #2;
      exp_q.push_back(mk(3'b000, 2'd0, 1'b0, 3'b000));
      e = exp_q.pop_front();
      a = sample();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL reset_mid_async: got gnt=%b idx=%0d busy=%b ef=%b, want gnt=%b idx=%0d busy=%b ef=%b",
                  a.gnt, a.idx, a.busy, a.ef, e.gnt, e.idx, e.busy, e.ef);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(3'b111, 3'b000, 1'b0, mk(3'b001, 2'd0, 1'b1, 3'b000));
      e = exp_q.pop_front();
      a = sample();
      checks++;
      if (a.gnt !== e.gnt || a.busy !== e.busy || a.idx !== e.idx) begin
         errors++;
         $display("FAIL reset_mid_restart: got gnt=%b idx=%0d busy=%b, want gnt=%b idx=%0d busy=%b",
                  a.gnt, a.idx, a.busy, e.gnt, e.idx, e.busy);
      end
   endtask

   task automatic test_timeout();
      obs_t       e, a;
      logic [2:0] cy, st, ef;
      logic       ack;
      apply_reset();
      // Grant, 3 stalls, ACK clears the count, then 4 stalls -> forced ERR.
      for (int i = 0; i < 13; i++) begin
         cy  = 3'b010;
         st  = 3'b010;
         ack = (i == 4);
         ef  = 3'b000;
         if (i == 8) ef = TO_ON ? 3'b010 : 3'b000;
         if (i == 10) cy = 3'b111;
         e = mk(3'b010, 2'd1, 1'b1, ef);
         if (i == 11) begin
            cy = 3'b101;
            st = 3'b000;
            e  = mk(3'b100, 2'd2, 1'b1, 3'b000);
         end
         if (i == 12) begin
            cy = 3'b000;
            st = 3'b000;
            e  = mk(3'b000, 2'd0, 1'b0, 3'b000);
         end
         drive(cy, st, ack, e);
         e = exp_q.pop_front();
         a = sample();
         checks++;
         if (a.gnt !== e.gnt || a.busy !== e.busy || a.ef !== e.ef || (e.busy && a.idx !== e.idx)) begin
            errors++;
            $display("FAIL timeout[%0d]: got gnt=%b idx=%0d busy=%b ef=%b, want gnt=%b idx=%0d busy=%b ef=%b",
                     i, a.gnt, a.idx, a.busy, a.ef, e.gnt, e.idx, e.busy, e.ef);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Round-robin arbiter for the shared-bus Wishbone interconnect. It selects which of NUMM masters (debug module, instruction port, data port) owns the single shared bus. It outputs a registered one-hot grant plus an encoded index; the interconnect's address/data muxes steer from these. Ownership is held for the whole Wishbone cycle (CYC high), so multi-beat and RMW sequences are never split.

Parameters:
NUMM, 3, number of masters (2..8)
TIMEOUT, 255, cycles a granted master may wait for ACK/ERR before forced abort (only with WB_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
m_cyc  in  NUMM  CYC from each master
m_stb  in  NUMM  STB from each master
s_ack  in  1  ACK from selected slave path
s_err  in  1  ERR from selected slave path
gnt  out  NUMM  one-hot grant, registered
gnt_idx  out  $clog2(NUMM)  encoded index of current owner, valid when busy=1
busy  out  1  bus owned by some master
m_err_force  out  NUMM  forced ERR to owner on timeout (tied 0 without feature)

Behaviour:
- Reset (rst_n low, async): gnt=0, gnt_idx=0, busy=0, m_err_force=0, state=IDLE, rr pointer last=NUMM-1, so master 0 has top priority first.
- States: IDLE, OWNED (plus ABORT with the feature).
- IDLE: if |m_cyc, winner = first set bit scanning last+1, last+2, ... modulo NUMM. Next cycle: gnt=onehot(winner), gnt_idx=winner, busy=1, last=winner, state=OWNED. Latency: m_cyc rise to gnt = 1 cycle.
- OWNED: hold while m_cyc[gnt_idx]=1; other requests are ignored.
- On the cycle m_cyc[gnt_idx]=0: if other requesters are pending, arbitrate in that same cycle (same scan from the updated last) and hand over next edge with no idle cycle. Otherwise go to IDLE with gnt=0 and busy=0 next cycle.
- The owner's own request is re-eligible only after all others in scan order, so no master is starved. Worst-case wait is (NUMM-1) cycles of other ownership.
- Simultaneous rise of all m_cyc from IDLE: pointer order decides, e.g. last=2 -> master 0.
- STB is not used for grant decisions. m_stb only qualifies the timeout counter.
- gnt never has more than one bit set. gnt=0 if and only if busy=0.
- An ACK/ERR arriving when busy=0 is ignored.
- Reset mid-cycle: grant dropped immediately and asynchronously. Masters must restart.

Optional Feature:
WB_ARB_TIMEOUT_EN
- Defined: an 8..16-bit counter clears on grant and on s_ack|s_err, and increments while m_stb[gnt_idx]=1 and busy. When it reaches TIMEOUT, m_err_force[gnt_idx] pulses for 1 cycle and state goes to ABORT. ABORT holds the grant until the owner drops CYC, then follows the normal OWNED release/handover rule. Protects against unmapped addresses hanging the core.
- Undefined: no counter, m_err_force hard-wired 0, no ABORT state.

Decomposition:
- Package wb_arb_pkg: state enum (IDLE, OWNED, ABORT), function rr_pick(req, last) returning the index, and the TIMEOUT counter width constant.
- One sub-module: wb_rr_pick, a combinational rotating priority encoder (req, last -> idx, valid). The FSM and registers stay in wb_rr_arbiter.

Test Plan:
- Single request: m_cyc=3'b010 after reset -> next cycle gnt=010, gnt_idx=1, busy=1. Drop cyc -> following cycle gnt=000, busy=0.
- Contention: all m_cyc=111 held, each owner drops cyc for 1 cycle after ack -> grant order 0,1,2,0 with no idle cycle between owners.
- Hold: owner 2 keeps cyc for 10 cycles while 0 and 1 request -> gnt stays 100 for all 10 cycles, then goes to 001.
- Back-to-back: owner 0 drops cyc while 1 requests -> gnt goes 001 to 010 on the next edge, busy never low.
- Reset mid-ownership: assert rst_n=0 during gnt=010 -> gnt=000 and busy=0 without waiting for clk. After release, m_cyc=111 -> master 0 granted.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT=4): master 1 stb with no ack -> m_err_force=010 for exactly 1 cycle after 4 stalled cycles. Grant is held until cyc drops. Without the macro, m_err_force stays 000.
